// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator.
// Buffers the two previous lines. For each accepted pixel from row 2 / column 2
// onward it registers a 9-pixel window (p00 in the MSBs .. p22 in the LSBs)
// together with regenerated sof/sol/eol/eof markers. Output frame is (W-2)x(H-2).
// Optional feature: define WINDOW_LINE_CHECK_EN to add the sticky err_line_len
// output, which flags any line whose length differs from the first line of the frame.
module window_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 1920
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_sof,
  input  logic                      in_sol,
  input  logic                      in_eol,
  input  logic                      in_eof,
  output logic                      out3x3_val,
  input  logic                      out3x3_rdy,
  output logic [9*DATA_WIDTH-1:0]   out3x3_data,
  output logic                      out3x3_sof,
  output logic                      out3x3_sol,
  output logic                      out3x3_eol,
  output logic                      out3x3_eof
`ifdef WINDOW_LINE_CHECK_EN
  ,
  output logic                      err_line_len
`endif
);

  // Column counter must be able to hold MAX_WIDTH itself (the "dropping" value).
  localparam int COL_W = $clog2(MAX_WIDTH + 1);
  localparam int AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH);
  localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROW0   = 2'd1,
    ROW1   = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t                  state;
  logic [COL_W-1:0]        col;
  logic [1:0]              row;
  logic                    first_win;

  logic                    acc;
  logic                    emit;
  logic                    in_range;
  logic                    wr_en;
  logic [COL_W-1:0]        col_eff;
  logic [AW-1:0]           rd_addr;

  // Line buffers: lb1 holds line r-1, lb2 holds line r-2.
  logic [DATA_WIDTH-1:0]   lb1 [0:MAX_WIDTH-1];
  logic [DATA_WIDTH-1:0]   lb2 [0:MAX_WIDTH-1];
  logic [DATA_WIDTH-1:0]   lb1_rd;
  logic [DATA_WIDTH-1:0]   lb2_rd;

  // Column shift registers, two taps per window row (tap0 is the oldest).
  logic [DATA_WIDTH-1:0]   row0_tap0_p0, row0_tap1_p0;
  logic [DATA_WIDTH-1:0]   row1_tap0_p0, row1_tap1_p0;
  logic [DATA_WIDTH-1:0]   row2_tap0_p0, row2_tap1_p0;
  logic [9*DATA_WIDTH-1:0] win_p0;

  // Registered output stage.
  logic                    vld_p1;
  logic [9*DATA_WIDTH-1:0] win_p1;
  logic                    sof_p1, sol_p1, eol_p1, eof_p1;

  // The input sol marker is redundant with the column counter.
  logic                    sol_unused;
  assign sol_unused = in_sol;

  assign in_rdy = ~vld_p1 | out3x3_rdy;
  assign acc    = in_val & in_rdy;

  // A sof pixel is always stored as column 0, whatever the counter says.
  always_comb begin
    col_eff  = in_sof ? '0 : col;
    in_range = (col_eff < COL_MAX);
    rd_addr  = '0;
    if (in_range) rd_addr = col_eff[AW-1:0];
    lb1_rd   = lb1[rd_addr];
    lb2_rd   = lb2[rd_addr];
    wr_en    = acc & ((state != IDLE) | in_sof) & in_range;
    emit     = acc & (state == STREAM) & ~in_sof & (col >= COL_TWO) & (col < COL_MAX);
  end

  // Line buffer update: the r-1 pixel ages into the r-2 buffer, the new pixel becomes r-1.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb2[rd_addr] <= lb1_rd;
      lb1[rd_addr] <= in_data;
    end
  end

  // Column shift: every accepted pixel pushes the current column into the taps.
  always_ff @(posedge clk) begin
    if (acc) begin
      row0_tap0_p0 <= row0_tap1_p0;
      row0_tap1_p0 <= lb2_rd;
      row1_tap0_p0 <= row1_tap1_p0;
      row1_tap1_p0 <= lb1_rd;
      row2_tap0_p0 <= row2_tap1_p0;
      row2_tap1_p0 <= in_data;
    end
  end

  // Window assembly: row 0 is the oldest line, column 0 the oldest pixel.
  always_comb begin
    win_p0 = {row0_tap0_p0, row0_tap1_p0, lb2_rd,
              row1_tap0_p0, row1_tap1_p0, lb1_rd,
              row2_tap0_p0, row2_tap1_p0, in_data};
  end

  // Frame tracking FSM with column/row counters; sof resynchronises from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      first_win <= 1'b0;
    end else if (acc) begin
      if (in_sof) begin
        state     <= in_eol ? ROW1 : ROW0;
        col       <= in_eol ? '0 : COL_W'(1);
        row       <= in_eol ? 2'd1 : 2'd0;
        first_win <= 1'b1;
      end else if (state != IDLE) begin
        if (in_eol) begin
          col <= '0;
          if (row != 2'd2) row <= row + 2'd1;
        end else if (col < COL_MAX) begin
          col <= col + COL_W'(1);
        end
        if (emit) first_win <= 1'b0;
        case (state)
          ROW0:    if (in_eol) state <= ROW1;
          ROW1:    if (in_eol) state <= STREAM;
          STREAM: begin
            if (in_eof) begin
              state <= IDLE;
              col   <= '0;
              row   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output register: load on an emitting accept, otherwise drop valid and markers once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      win_p1 <= '0;
      sof_p1 <= 1'b0;
      sol_p1 <= 1'b0;
      eol_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else if (emit) begin
      vld_p1 <= 1'b1;
      win_p1 <= win_p0;
      sof_p1 <= first_win;
      sol_p1 <= (col == COL_TWO);
      eol_p1 <= in_eol;
      eof_p1 <= in_eof;
    end else if (out3x3_rdy) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      sol_p1 <= 1'b0;
      eol_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end
  end

  assign out3x3_val  = vld_p1;
  assign out3x3_data = win_p1;
  assign out3x3_sof  = sof_p1;
  assign out3x3_sol  = sol_p1;
  assign out3x3_eol  = eol_p1;
  assign out3x3_eof  = eof_p1;

`ifdef WINDOW_LINE_CHECK_EN
  localparam int LEN_W = COL_W + 1;

  logic [LEN_W-1:0] first_len;
  logic [LEN_W-1:0] cur_len;
  logic             have_len;

  assign cur_len = {1'b0, col} + LEN_W'(1);

  // Latch the first line length of the frame and flag any later line that differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_len    <= '0;
      have_len     <= 1'b0;
      err_line_len <= 1'b0;
    end else if (acc) begin
      if (in_sof) begin
        have_len  <= in_eol;
        first_len <= LEN_W'(1);
      end else if ((state != IDLE) && in_eol) begin
        if (!have_len) begin
          first_len <= cur_len;
          have_len  <= 1'b1;
        end else if (cur_len != first_len) begin
          err_line_len <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen: a per-column pixel history model predicts
// each window at stimulus time; a monitor pops and compares on every output transfer.
module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int MW = 8;

  typedef struct packed {
    logic [9*DW-1:0] data;
    logic            sof;
    logic            sol;
    logic            eol;
    logic            eof;
  } win_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_val = 1'b0;
  logic            in_rdy;
  logic [DW-1:0]   in_data = '0;
  logic            in_sof = 1'b0, in_sol = 1'b0, in_eol = 1'b0, in_eof = 1'b0;
  logic            out_val;
  logic            out_rdy = 1'b1;
  logic [9*DW-1:0] out_data;
  logic            out_sof, out_sol, out_eol, out_eof;
`ifdef WINDOW_LINE_CHECK_EN
  logic            err_len;
`endif

  window_3x3_gen #(.DATA_WIDTH(DW), .MAX_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .in_sof(in_sof), .in_sol(in_sol), .in_eol(in_eol), .in_eof(in_eof),
    .out3x3_val(out_val), .out3x3_rdy(out_rdy), .out3x3_data(out_data),
    .out3x3_sof(out_sof), .out3x3_sol(out_sol), .out3x3_eol(out_eol), .out3x3_eof(out_eof)
`ifdef WINDOW_LINE_CHECK_EN
    , .err_line_len(err_len)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_win = 0;
  win_t exp_q[$];
  win_t got_q[$];

  // Reference model state: per-column history of the last three pixels written.
  logic [DW-1:0] hist [MW][3];
  bit m_active = 0;
  int m_r = 0;
  int m_c = 0;
  bit m_first = 0;

  int rdy_mode = 0;
  int rdy_idx = 0;
  bit bubbles = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [9*DW-1:0] win9(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
    return {a0[7:0], a1[7:0], a2[7:0], a3[7:0], a4[7:0], a5[7:0], a6[7:0], a7[7:0], a8[7:0]};
  endfunction

  // Model: a pixel at (r, c) with r>=2, c>=2 in an active frame yields the window of
  // the last three pixels seen in each of columns c-2..c.
  task automatic model_accept(input logic [DW-1:0] d, input bit sof, input bit eol, input bit eof);
    win_t e;
    bit was_stream;
    if (sof) begin
      m_active = 1; m_r = 0; m_c = 0; m_first = 1;
    end
    if (m_active) begin
      was_stream = (m_r >= 2);
      if (m_c < MW) begin
        hist[m_c][0] = hist[m_c][1];
        hist[m_c][1] = hist[m_c][2];
        hist[m_c][2] = d;
        if (m_r >= 2 && m_c >= 2) begin
          e.data = {hist[m_c-2][0], hist[m_c-1][0], hist[m_c][0],
                    hist[m_c-2][1], hist[m_c-1][1], hist[m_c][1],
                    hist[m_c-2][2], hist[m_c-1][2], hist[m_c][2]};
          e.sof = m_first;
          e.sol = (m_c == 2);
          e.eol = eol;
          e.eof = eof;
          exp_q.push_back(e);
          m_first = 0;
        end
      end
      if (eol) begin
        m_c = 0;
        if (m_r < 2) m_r++;
      end else if (m_c < MW) begin
        m_c++;
      end
      if (eof && was_stream) m_active = 0;
    end
  endtask

  task automatic set_rdy();
    case (rdy_mode)
      0: out_rdy = 1'b1;
      1: begin out_rdy = pat[rdy_idx % 4]; rdy_idx++; end
      default: out_rdy = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic idle_cycle();
    in_val = 1'b0;
    set_rdy();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one pixel from a negedge until it is accepted; returns at a negedge.
  task automatic send(input logic [DW-1:0] d, input bit sof, input bit sol, input bit eol, input bit eof);
    bit done;
    int guard;
    done = 0;
    guard = 0;
    if (bubbles && $urandom_range(0, 3) == 0) idle_cycle();
    in_data = d; in_sof = sof; in_sol = sol; in_eol = eol; in_eof = eof;
    in_val = 1'b1;
    while (!done) begin
      set_rdy();
      #1;
      if (in_rdy) begin
        model_accept(d, sof, eol, eof);
        done = 1;
      end
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (!done && guard > 200) begin
        $display("FAIL send_timeout actual=stalled required=accepted");
        failures++;
        $fatal(1, "input never accepted");
      end
    end
    in_val = 1'b0;
    in_sof = 1'b0; in_sol = 1'b0; in_eol = 1'b0; in_eof = 1'b0;
  endtask

  // Send a w x h frame (first 'stop' pixels only when stop >= 0).
  task automatic send_frame(input int w, input int h, input bit rnd, input int base, input int stop);
    int k;
    logic [DW-1:0] d;
    k = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (stop < 0 || k < stop) begin
          d = rnd ? DW'($urandom) : DW'(base + k);
          send(d, (r == 0 && c == 0), (c == 0), (c == w - 1), (r == h - 1 && c == w - 1));
        end
        k++;
      end
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    in_val = 1'b0;
    while ((exp_q.size() != 0 || out_val) && guard < 60) begin
      out_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  // Monitor: compares every transfer against the scoreboard and checks stall behaviour.
  initial begin
    win_t e;
    win_t held;
    bit was_stalled;
    was_stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check("in_rdy", in_rdy, (!out_val || out_rdy));
        if (was_stalled && out_val)
          check("stall_hold", {out_data, out_sof, out_sol, out_eol, out_eof}, held);
        if (out_val && out_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_window actual=%0h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("win_data", out_data, e.data);
            check("win_markers", {out_sof, out_sol, out_eol, out_eof}, {e.sof, e.sol, e.eol, e.eof});
          end
          got_q.push_back({out_data, out_sof, out_sol, out_eol, out_eof});
          n_win++;
        end
        was_stalled = out_val && !out_rdy;
        held = {out_data, out_sof, out_sol, out_eol, out_eof};
      end else begin
        was_stalled = 0;
      end
    end
  end

  initial begin
    int n0, g0, g1, nsof, w, h, wf;
    rst_n = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_val", out_val, 0);
    check("rst_data", out_data, 0);
    check("rst_markers", {out_sof, out_sol, out_eol, out_eof}, 0);
    check("rst_in_rdy", in_rdy, 1);
`ifdef WINDOW_LINE_CHECK_EN
    check("rst_err", err_len, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 4x4 frame, pixels 0..15, always ready.
    rdy_mode = 0;
    n0 = n_win; g0 = got_q.size();
    send_frame(4, 4, 0, 0, -1);
    drain("t1");
    check("t1_count", n_win - n0, 4);
    check("t1_first", got_q[g0].data, win9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    check("t1_first_mk", {got_q[g0].sof, got_q[g0].sol, got_q[g0].eol, got_q[g0].eof}, 4'b1100);
    check("t1_second", got_q[g0+1].data, win9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    check("t1_second_mk", {got_q[g0+1].sof, got_q[g0+1].sol, got_q[g0+1].eol, got_q[g0+1].eof}, 4'b0010);
    check("t1_last", got_q[g0+3].data, win9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    check("t1_last_mk", {got_q[g0+3].sof, got_q[g0+3].sol, got_q[g0+3].eol, got_q[g0+3].eof}, 4'b0011);

    // Same frame with downstream ready toggling 1,0,0,1.
    rdy_mode = 1; rdy_idx = 0;
    n0 = n_win; g1 = got_q.size();
    send_frame(4, 4, 0, 0, -1);
    drain("t2");
    check("t2_count", n_win - n0, 4);
    for (int i = 0; i < 4; i++) check("t2_same_seq", got_q[g1+i], got_q[g0+i]);

    // Pixels before sof are ignored, then a 5x3 frame.
    rdy_mode = 0;
    n0 = n_win; g0 = got_q.size();
    send(8'hAA, 0, 1, 0, 0);
    send(8'hBB, 0, 0, 1, 0);
    send(8'hCC, 0, 0, 1, 1);
    send_frame(5, 3, 1, 0, -1);
    drain("t3");
    check("t3_count", n_win - n0, 3);
    nsof = 0;
    for (int i = g0; i < got_q.size(); i++) nsof += int'(got_q[i].sof);
    check("t3_sof_once", nsof, 1);
    check("t3_sof_first", got_q[g0].sof, 1);

    // Abort a 4x4 frame after pixel (2,2) with a new sof, then a clean 4x4.
    rdy_mode = 2;
    n0 = n_win;
    send_frame(4, 4, 1, 0, 11);
    send_frame(4, 4, 1, 0, -1);
    drain("t4");
    check("t4_count", n_win - n0, 5);

    // Reset during row 3 while a window is valid.
    rdy_mode = 0;
    send_frame(4, 4, 0, 40, 15);
    check("t5_pre_val", out_val, 1);
    rst_n = 1'b0;
    in_val = 1'b0;
    #1;
    check("t5_rst_val", out_val, 0);
    check("t5_rst_in_rdy", in_rdy, 1);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_markers", {out_sof, out_sol, out_eol, out_eof}, 0);
    exp_q.delete();
    m_active = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h11, 0, 0, 0, 0);
    send(8'h22, 0, 0, 1, 0);
    n0 = n_win;
    send_frame(4, 4, 0, 100, -1);
    drain("t5");
    check("t5_count", n_win - n0, 4);

    // Random frames, including lines longer than the line buffers.
    rdy_mode = 2; bubbles = 1;
    for (int f = 0; f < 6; f++) begin
      w = (f == 0) ? 10 : $urandom_range(3, 10);
      h = $urandom_range(3, 6);
      wf = (w < MW) ? w : MW;
      n0 = n_win;
      send_frame(w, h, 1, 0, -1);
      drain("rnd");
      check("rnd_count", n_win - n0, (wf - 2) * (h - 2));
    end
    bubbles = 0;

    // Line lengths 4,4,3,4.
    rdy_mode = 0;
    n0 = n_win;
`ifdef WINDOW_LINE_CHECK_EN
    check("t6_err_before", err_len, 0);
`endif
    for (int r = 0; r < 4; r++) begin
      w = (r == 2) ? 3 : 4;
      for (int c = 0; c < w; c++)
        send(DW'(r * 16 + c), (r == 0 && c == 0), (c == 0), (c == w - 1), (r == 3 && c == w - 1));
`ifdef WINDOW_LINE_CHECK_EN
      if (r == 1) check("t6_err_after2", err_len, 0);
      if (r == 2) check("t6_err_after3", err_len, 1);
`endif
    end
    drain("t6");
    check("t6_count", n_win - n0, 3);
`ifdef WINDOW_LINE_CHECK_EN
    repeat (3) @(negedge clk);
    check("t6_err_sticky", err_len, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
